// File: rtl/mem_access_stage_if.sv
// Data-cache request/response bus between the memory-access stage (master)
// and the data cache (slave).
interface mem_access_stage_if;
   logic        dc_req;
   logic        dc_we;
   logic [31:0] dc_addr;
   logic [31:0] dc_wdata;
   logic [3:0]  dc_be;
   logic        dc_ready;
   logic [31:0] dc_rdata;

   modport master (
      output dc_req, dc_we, dc_addr, dc_wdata, dc_be,
      input  dc_ready, dc_rdata
   );

   modport slave (
      input  dc_req, dc_we, dc_addr, dc_wdata, dc_be,
      output dc_ready, dc_rdata
   );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues load/store requests to the data cache, stalls
// upstream while a request is outstanding and emits one writeback record per op.
// Cache handshake: dc_req stays high with all dc_* fields frozen until the
// edge on which dc_ready=1 is sampled; that edge retires the access.
module mem_access_stage (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_in,
   input  logic [31:0]                alu_result,
   input  logic [31:0]                store_data,
   input  logic                       is_load_in,
   input  logic                       is_store_in,
   input  logic                       is_write_in,
   input  logic                       is_byte_in,
   input  logic [4:0]                 rd_in,
   output logic                       stall_out,
   mem_access_stage_if.master         dc,
   output logic                       wb_valid,
   output logic                       wb_write,
   output logic [4:0]                 wb_rd,
   output logic [31:0]                wb_data,
   output logic                       exc_misaligned,
   output logic                       state_dbg
);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [1:0]  off_q, off_d;
   logic        byte_q, byte_d;
   logic [4:0]  rd_q, rd_d;
   logic        wb_valid_d, wb_write_d, exc_d;
   logic [4:0]  wb_rd_d;
   logic [31:0] wb_data_d;
   logic [7:0]  ld_byte;
   logic        is_mem, misaligned;

   assign is_mem     = is_load_in | is_store_in;
   assign misaligned = is_mem && !is_byte_in && (alu_result[1:0] != 2'b00);

   // dc_req tracks the state flop, so reset withdraws it immediately
   assign dc.dc_req   = (state_q == REQ);
   assign dc.dc_we    = we_q;
   assign dc.dc_addr  = addr_q;
   assign dc.dc_wdata = wdata_q;
   assign dc.dc_be    = be_q;
   assign stall_out   = (state_q == REQ);
   assign state_dbg   = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (valid_in && is_mem && !misaligned) state_d = REQ;
         REQ:     if (dc.dc_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      case (off_q)
         2'd0:    ld_byte = dc.dc_rdata[7:0];
         2'd1:    ld_byte = dc.dc_rdata[15:8];
         2'd2:    ld_byte = dc.dc_rdata[23:16];
         default: ld_byte = dc.dc_rdata[31:24];
      endcase
   end

   always_comb begin
      wb_valid_d = 1'b0;
      wb_write_d = 1'b0;
      exc_d      = 1'b0;
      wb_rd_d    = wb_rd;
      wb_data_d  = wb_data;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      off_d      = off_q;
      byte_d     = byte_q;
      rd_d       = rd_q;
      case (state_q)
         IDLE: begin
            if (valid_in) begin
               if (!is_mem) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = alu_result;
                  wb_rd_d    = rd_in;
                  wb_write_d = is_write_in && (rd_in != 5'd0);
               end else if (misaligned) begin
                  wb_valid_d = 1'b1;
                  exc_d      = 1'b1;
                  wb_data_d  = alu_result;
                  wb_rd_d    = rd_in;
               end else begin
                  we_d    = is_store_in;
                  addr_d  = {alu_result[31:2], 2'b00};
                  be_d    = is_byte_in ? (4'b0001 << alu_result[1:0]) : 4'b1111;
                  wdata_d = is_byte_in ? {4{store_data[7:0]}} : store_data;
                  off_d   = alu_result[1:0];
                  byte_d  = is_byte_in;
                  rd_d    = rd_in;
               end
            end
         end
         REQ: begin
            if (dc.dc_ready) begin
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               if (!we_q) begin
                  wb_write_d = (rd_q != 5'd0);
                  wb_data_d  = byte_q ? {{24{ld_byte[7]}}, ld_byte} : dc.dc_rdata;
               end else begin
                  wb_data_d  = 32'd0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q           <= 1'b0;
         addr_q         <= 32'd0;
         wdata_q        <= 32'd0;
         be_q           <= 4'd0;
         off_q          <= 2'd0;
         byte_q         <= 1'b0;
         rd_q           <= 5'd0;
         wb_valid       <= 1'b0;
         wb_write       <= 1'b0;
         wb_rd          <= 5'd0;
         wb_data        <= 32'd0;
         exc_misaligned <= 1'b0;
      end else begin
         we_q           <= we_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         be_q           <= be_d;
         off_q          <= off_d;
         byte_q         <= byte_d;
         rd_q           <= rd_d;
         wb_valid       <= wb_valid_d;
         wb_write       <= wb_write_d;
         wb_rd          <= wb_rd_d;
         wb_data        <= wb_data_d;
         exc_misaligned <= exc_d;
      end
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage placed directly downstream of the ALU stage in the multi-cycle cache pipeline. It takes the ALU result as the effective address for loads and stores, or as the writeback value for everything else. It runs the request/ready handshake with the data cache, stalls upstream while a cache access is outstanding, and presents one registered writeback record per accepted instruction.

## Interface
- `RESET_PC`: none. The block has no parameters. All widths are fixed: 32-bit data, 5-bit register index.
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset; state clears immediately on assertion and releases synchronously with `clk`
- `valid_in`  in  1  upstream instruction present this cycle
- `alu_result`  in  32  effective address (load/store) or result value (other)
- `store_data`  in  32  rs2 value for stores
- `is_load_in` / `is_store_in` / `is_write_in`  in  1 each  op class; load and store are never both 1
- `is_byte_in`  in  1  1 = byte access, 0 = word access
- `rd_in`  in  5  destination register
- `stall_out`  out  1  1 = stage busy; upstream must hold its inputs stable
- `dc_req`  out  1  cache request, registered
- `dc_we`  out  1  1 = store
- `dc_addr`  out  32  word-aligned address ({addr[31:2],2'b00})
- `dc_wdata`  out  32  store data, lane-replicated for byte stores
- `dc_be`  out  4  byte enables
- `dc_ready`  in  1  cache completes the request this cycle
- `dc_rdata`  in  32  read word, valid when `dc_ready`=1
- `wb_valid`  out  1  one-cycle pulse; writeback record valid
- `wb_write`  out  1  register-file write enable
- `wb_rd`  out  5  destination register
- `wb_data`  out  32  value to write
- `exc_misaligned`  out  1  one-cycle pulse, coincident with `wb_valid`

## Operation
- FSM states: IDLE, REQ.
- An instruction is accepted when state=IDLE and `valid_in`=1. `stall_out` = (state==REQ).
- Non-memory op accepted:
  - next edge: `wb_valid`=1, `wb_data`=`alu_result`, `wb_rd`=`rd_in`, `wb_write`=`is_write_in` && (`rd_in`!=0).
  - FSM stays in IDLE.
- Misaligned access (word access with `alu_result[1:0]`!=0):
  - no cache request is issued.
  - next edge: `wb_valid`=1, `exc_misaligned`=1, `wb_write`=0, `wb_data`=`alu_result`.
  - FSM stays in IDLE.
- Aligned load or store accepted: on the next edge go to REQ and register:
  - `dc_req`=1, `dc_we`=`is_store_in`, `dc_addr`
  - `dc_be`: word = 4'b1111; byte = 4'b0001<<addr[1:0]
  - `dc_wdata`: word = `store_data`; byte = {4{store_data[7:0]}}
  - byte offset, byte flag and `rd_in`, held internally.
- REQ state:
  - all `dc_*` outputs stay constant until `dc_ready`=1 is sampled.
  - on that edge: `dc_req`→0, state→IDLE, `wb_valid`=1.
  - load: `wb_write`=(rd!=0); `wb_data` = `dc_rdata` (word) or the sign-extended byte `dc_rdata[8*off+7:8*off]`.
  - store: `wb_write`=0, `wb_data`=0.
- `dc_ready` is ignored in IDLE.
- `valid_in` is ignored in REQ; upstream is stalled.
- `wb_valid` and `exc_misaligned` are 0 in every cycle not listed above.

## Timing
- Reset values: every output is 0, state=IDLE. This includes `dc_req`, `stall_out`, `wb_valid`, `wb_write`, `wb_rd`, `wb_data`, `dc_addr`, `dc_wdata`, `dc_be`, `dc_we` and `exc_misaligned`.
- Non-memory or misaligned op: 1-cycle latency. One instruction can be accepted per cycle, back-to-back.
- Memory op accepted at edge E0:
  - `dc_req`=1 and `stall_out`=1 from E0.
  - if `dc_ready` is first sampled 1 at edge En (n≥1): `wb_valid` is high for the cycle after En, and `stall_out` falls at En.
  - a new instruction can be accepted at En+1.
- Zero-wait cache (`dc_ready`=1 in the first REQ cycle): a memory op occupies 2 cycles.
- Reset asserted while in REQ:
  - `dc_req` drops asynchronously and the pending access is abandoned.
  - no `wb_valid` is produced for it.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0. Release and send ADD result 0x0000_1234 with rd=5 → next cycle `wb_valid`=1, `wb_data`=0x1234, `wb_rd`=5, `wb_write`=1.
- Word load at addr 0x100, rd=3, `dc_ready` high on the 3rd REQ cycle with `dc_rdata`=0xDEADBEEF:
  - `dc_req` is high for 3 cycles with `dc_addr`=0x100, `dc_be`=4'hF.
  - `stall_out` is high for 3 cycles.
  - then `wb_data`=0xDEADBEEF, `wb_write`=1.
- Byte load at addr 0x203, `dc_rdata`=0x80112233, zero-wait → `wb_data`=0xFFFFFF80. Repeat at 0x202 → `wb_data`=0x00000011.
- Byte store at 0x101 with `store_data`=0x000000AB → `dc_we`=1, `dc_be`=4'b0010, `dc_wdata`=0xABABABAB, `dc_addr`=0x100. Then `wb_valid`=1 with `wb_write`=0.
- Word load at 0x102 → no `dc_req`; next cycle `wb_valid`=1, `exc_misaligned`=1, `wb_write`=0. A load with rd=0 completes with `wb_write`=0.
- Assert `rst` in the second REQ cycle of a store → `dc_req` goes to 0 immediately. After release: no `wb_valid`, state IDLE, `stall_out`=0.
